vic_ext_cond: RTL and testbench

- Input conditioner for external interrupt lines. Feeds the i_ext[30:0] bus of the Vic top, which performs edge/level detection and priority.
- Each asynchronous line passes through a multi-flop synchronizer, then a programmable-length debounce/glitch filter.
- Only clean, single-clock-domain levels reach the VIC.
- Instantiated between the pad/peripheral interrupt sources and the Vic.

---
 rtl/vic_ext_cond.sv | 130 +++++++++++++
 tb/tb_vic_ext_cond.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vic_ext_cond.sv
// ---------------------------------------------------------------------------
// vic_ext_cond -- input conditioner for the Vic external interrupt lines.
//
// Each asynchronous line passes through a SYNC_STAGES-deep synchronizer and
// then a debounce/glitch filter. The filter changes its output only after the
// synchronized level has differed from it for Leff consecutive cycles, where
//   Leff = i_filt_en[line] ? max(i_filt_len, 1) : 1.
// Only clean, registered, single-domain levels reach the Vic.
//
// Ports:
//   clk         system clock (single domain)
//   rst         synchronous active-high reset
//   i_ext_raw   [N_LINES] asynchronous external interrupt lines
//   i_filt_len  [FILT_W]  filter length L (0 behaves as 1)
//   i_filt_en   [N_LINES] per-line filter enable (0 forces L=1)
//   o_ext       [N_LINES] conditioned levels to Vic i_ext
//
// Optional feature, macro VIC_EXT_ACT_EN:
//   i_act_clr   [N_LINES] per-line activity clear
//   o_activity  [N_LINES] sticky "filtered level changed" flags; a set in the
//                         same cycle as a clear wins
// ---------------------------------------------------------------------------
module vic_ext_cond #(
  parameter int N_LINES     = 31,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] i_ext_raw,
  input  logic [FILT_W-1:0]  i_filt_len,
  input  logic [N_LINES-1:0] i_filt_en,
`ifdef VIC_EXT_ACT_EN
  input  logic [N_LINES-1:0] i_act_clr,
  output logic [N_LINES-1:0] o_activity,
`endif
  output logic [N_LINES-1:0] o_ext
);

  // Threshold on the counter: a change is accepted once C >= Leff-1.
  // A programmed length of 0 is treated as 1, giving threshold 0.
  function automatic logic [FILT_W-1:0] len_to_thr(input logic [FILT_W-1:0] len);
    logic [FILT_W-1:0] thr;
    if (len == {FILT_W{1'b0}}) begin
      thr = {FILT_W{1'b0}};
    end else begin
      thr = len - FILT_W'(1);
    end
    return thr;
  endfunction

  logic [SYNC_STAGES-1:0][N_LINES-1:0] sync_q, sync_d;
  logic [N_LINES-1:0]                  filt_q, filt_d;
  logic [N_LINES-1:0][FILT_W-1:0]      cnt_q,  cnt_d;
  logic [N_LINES-1:0]                  sync_lvl_s;
  logic [FILT_W-1:0]                   thr_en_s;

  assign sync_lvl_s = sync_q[SYNC_STAGES-1];
  assign thr_en_s   = len_to_thr(i_filt_len);

  // Synchronizer shift: plain flop chain, no logic between stages.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = i_ext_raw;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-line filter: count cycles the synchronized level differs from the
  // output. The >= compare lets a lowered length take effect immediately, and
  // any agreeing cycle restarts the count so pulses never accumulate credit.
  always_comb begin
    logic [FILT_W-1:0] line_thr;
    filt_d   = filt_q;
    cnt_d    = cnt_q;
    line_thr = {FILT_W{1'b0}};
    for (int i = 0; i < N_LINES; i++) begin
      if (i_filt_en[i]) begin
        line_thr = thr_en_s;
      end else begin
        line_thr = {FILT_W{1'b0}};
      end
      if (sync_lvl_s[i] == filt_q[i]) begin
        cnt_d[i] = {FILT_W{1'b0}};
      end else if (cnt_q[i] >= line_thr) begin
        filt_d[i] = sync_lvl_s[i];
        cnt_d[i]  = {FILT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  // State registers for synchronizer, filter output and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_ext = filt_q;

`ifdef VIC_EXT_ACT_EN
  logic [N_LINES-1:0] act_q, act_d;

  // Sticky activity flags: set on any filtered-level change, set beats clear.
  always_comb begin
    act_d = (act_q & ~i_act_clr) | (filt_d ^ filt_q);
  end

  // Activity flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
    end else begin
      act_q <= act_d;
    end
  end

  assign o_activity = act_q;
`endif

endmodule

// File: tb/tb_vic_ext_cond.sv
module tb_vic_ext_cond;

  localparam int N    = 31;
  localparam int SYNC = 2;
  localparam logic [30:0] ALL    = 31'h7FFF_FFFF;
  localparam logic [30:0] EN_BYP = 31'h7FFF_FFFE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  i_ext_raw = '0;
  logic [3:0]    i_filt_len = 4'd4;
  logic [N-1:0]  i_filt_en = ALL;
  logic [N-1:0]  o_ext;
`ifdef VIC_EXT_ACT_EN
  logic [N-1:0]  i_act_clr = '0;
  logic [N-1:0]  o_activity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vic_ext_cond #(.N_LINES(N), .SYNC_STAGES(SYNC), .FILT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_ext_raw  (i_ext_raw),
    .i_filt_len (i_filt_len),
    .i_filt_en  (i_filt_en),
`ifdef VIC_EXT_ACT_EN
    .i_act_clr  (i_act_clr),
    .o_activity (o_activity),
`endif
    .o_ext      (o_ext)
  );

  always #5 clk = ~clk;

  // Reference model: the synchronized level is the raw input delayed by SYNC
  // samples (zeros after reset); an output flips once the synchronized level
  // has disagreed with it on the last Leff consecutive edges.
  logic [N-1:0] m_pipe [SYNC];
  logic [N-1:0] m_out;
  int           m_run [N];

  task automatic model_edge(input logic r, input logic [N-1:0] raw,
                            input logic [3:0] len, input logic [N-1:0] en);
    logic [N-1:0] s;
    int leff;
    if (r) begin
      for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
      m_out = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      s = m_pipe[SYNC-1];
      for (int i = 0; i < N; i++) begin
        leff = (en[i] && len != 4'd0) ? int'(len) : 1;
        if (s[i] != m_out[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] >= leff) begin
          m_out[i] = s[i];
          m_run[i] = 0;
        end
      end
      for (int k = SYNC-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = raw;
    end
  endtask

  // Drive inputs on the falling edge, take the rising edge, sample 1ns later.
  task automatic step(input logic r, input logic [N-1:0] raw,
                      input logic [3:0] len, input logic [N-1:0] en);
    @(negedge clk);
    rst = r; i_ext_raw = raw; i_filt_len = len; i_filt_en = en;
    @(posedge clk);
    model_edge(r, raw, len, en);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] raw;
    logic [3:0]   len;
    logic [N-1:0] en;
    logic [N-1:0] exp;
    string        name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [N-1:0] raw, input logic [3:0] len,
                              input logic [N-1:0] en, input logic [N-1:0] exp, input string nm);
    vec_t v;
    v.rst = r; v.raw = raw; v.len = len; v.en = en; v.exp = exp; v.name = nm;
    return v;
  endfunction

  initial begin
    // Reset and steady state: all-ones appears at edge 6 after release.
    tbl.push_back(mk(1'b1, ALL, 4'd4, ALL, '0, "rst_hold0"));
    tbl.push_back(mk(1'b1, ALL, 4'd4, ALL, '0, "rst_hold1"));
    for (int e = 1; e <= 5; e++) tbl.push_back(mk(1'b0, ALL, 4'd4, ALL, '0, "rise_wait"));
    tbl.push_back(mk(1'b0, ALL, 4'd4, ALL, ALL, "rise_edge6"));
    // Glitch rejection on line 5: 3-cycle pulse suppressed, 4-cycle passes.
    tbl.push_back(mk(1'b1, '0, 4'd4, ALL, '0, "glitch_rst"));
    tbl.push_back(mk(1'b0, '0, 4'd4, ALL, '0, "glitch_idle"));
    for (int e = 0; e < 3; e++) tbl.push_back(mk(1'b0, 31'h20, 4'd4, ALL, '0, "glitch3_in"));
    for (int e = 0; e < 3; e++) tbl.push_back(mk(1'b0, '0, 4'd4, ALL, '0, "glitch3_out"));
    for (int e = 0; e < 4; e++) tbl.push_back(mk(1'b0, 31'h20, 4'd4, ALL, '0, "pulse4_in"));
    tbl.push_back(mk(1'b0, '0, 4'd4, ALL, '0, "pulse4_e5"));
    for (int e = 0; e < 4; e++) tbl.push_back(mk(1'b0, '0, 4'd4, ALL, 31'h20, "pulse4_high"));
    tbl.push_back(mk(1'b0, '0, 4'd4, ALL, '0, "pulse4_fall"));
    tbl.push_back(mk(1'b0, '0, 4'd4, ALL, '0, "pulse4_low"));
    // Bypass on line 0, L=15 on line 1.
    tbl.push_back(mk(1'b1, '0, 4'd15, EN_BYP, '0, "byp_rst"));
    tbl.push_back(mk(1'b0, 31'h3, 4'd15, EN_BYP, '0, "byp_e1"));
    tbl.push_back(mk(1'b0, '0, 4'd15, EN_BYP, '0, "byp_e2"));
    tbl.push_back(mk(1'b0, '0, 4'd15, EN_BYP, 31'h1, "byp_e3"));
    tbl.push_back(mk(1'b0, '0, 4'd15, EN_BYP, '0, "byp_e4"));
    tbl.push_back(mk(1'b0, '0, 4'd15, EN_BYP, '0, "byp_e5"));
    // Dynamic length: L=10 counting to C=5, then L=3 flips next edge; L=0 acts as 1.
    tbl.push_back(mk(1'b1, '0, 4'd10, ALL, '0, "dyn_rst"));
    for (int e = 1; e <= 7; e++) tbl.push_back(mk(1'b0, 31'h4, 4'd10, ALL, '0, "dyn_count"));
    tbl.push_back(mk(1'b0, 31'h4, 4'd3, ALL, 31'h4, "dyn_lower"));
    tbl.push_back(mk(1'b0, '0, 4'd0, ALL, 31'h4, "len0_e9"));
    tbl.push_back(mk(1'b0, '0, 4'd0, ALL, 31'h4, "len0_e10"));
    tbl.push_back(mk(1'b0, '0, 4'd0, ALL, '0, "len0_fall"));
    // Mid-operation reset on line 7 at C=2.
    tbl.push_back(mk(1'b1, '0, 4'd4, ALL, '0, "mid_rst0"));
    for (int e = 1; e <= 4; e++) tbl.push_back(mk(1'b0, 31'h80, 4'd4, ALL, '0, "mid_count"));
    tbl.push_back(mk(1'b1, 31'h80, 4'd4, ALL, '0, "mid_rst"));
    for (int e = 1; e <= 5; e++) tbl.push_back(mk(1'b0, 31'h80, 4'd4, ALL, '0, "mid_wait"));
    tbl.push_back(mk(1'b0, 31'h80, 4'd4, ALL, 31'h80, "mid_rise"));

    foreach (tbl[j]) begin
      step(tbl[j].rst, tbl[j].raw, tbl[j].len, tbl[j].en);
      check(tbl[j].name, o_ext, tbl[j].exp);
    end

`ifdef VIC_EXT_ACT_EN
    // Activity: set on F change, set beats same-cycle clear, lone clear clears.
    step(1'b1, '0, 4'd1, '0);
    check("act_rst", o_activity, '0);
    step(1'b0, 31'h8, 4'd1, '0);
    step(1'b0, 31'h8, 4'd1, '0);
    check("act_before", o_activity, '0);
    step(1'b0, 31'h8, 4'd1, '0);
    check("act_rise_o", o_ext, 31'h8);
    check("act_set", o_activity, 31'h8);
    step(1'b0, '0, 4'd1, '0);
    step(1'b0, '0, 4'd1, '0);
    i_act_clr = 31'h8;
    step(1'b0, '0, 4'd1, '0);
    check("act_fall_o", o_ext, '0);
    check("act_set_wins", o_activity, 31'h8);
    step(1'b0, '0, 4'd1, '0);
    i_act_clr = '0;
    check("act_clear", o_activity, '0);
`endif

    // Randomized run against the reference model.
    begin
      logic [N-1:0] raw, en;
      logic [3:0]   len;
      logic         r;
      raw = '0; en = ALL; len = 4'd4;
      step(1'b1, raw, len, en);
      check("rand_rst", o_ext, m_out);
      for (int c = 0; c < 4000; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 5) == 0) raw[i] = ~raw[i];
        if ($urandom_range(0, 40) == 0) len = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 300) == 0) en = N'($urandom);
        r = ($urandom_range(0, 400) == 0);
        step(r, raw, len, en);
        check("rand_model", o_ext, m_out);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
